// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared pipeline definitions for the hazard/forwarding controller: operand-mux select
// encoding, controller FSM states and default widths.
package hazard_fwd_ctrl_pkg;

  localparam int REG_AW = 5;
  localparam int CNT_W  = 16;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF    = 2'b00;
  localparam fwd_sel_t FWD_EXMEM = 2'b01;
  localparam fwd_sel_t FWD_MEMWB = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_FREEZE = 2'd2
  } state_t;

endpackage

// File: rtl/hazard_fwd_ctrl_if.sv
// ID-stage hazard inputs and EX-mux / pipeline-enable outputs of the hazard controller.
// master = pipeline datapath side, slave = controller side.
interface hazard_fwd_ctrl_if #(
  parameter int REG_AW = hazard_fwd_ctrl_pkg::REG_AW,
  parameter int CNT_W  = hazard_fwd_ctrl_pkg::CNT_W
);
  import hazard_fwd_ctrl_pkg::*;

  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] id_rd;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              flush;
  logic              mem_wait;

  fwd_sel_t          fwd_a_sel;
  fwd_sel_t          fwd_b_sel;
  logic              pc_write;
  logic              ifid_write;
  logic              ifid_flush;
  logic              idex_bubble;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output id_valid, id_rs, id_rt, id_rd, id_reg_write, id_mem_read, flush, mem_wait,
    input  fwd_a_sel, fwd_b_sel, pc_write, ifid_write, ifid_flush, idex_bubble, stall_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rd, id_reg_write, id_mem_read, flush, mem_wait,
    output fwd_a_sel, fwd_b_sel, pc_write, ifid_write, ifid_flush, idex_bubble, stall_count
  );

endinterface

// File: rtl/hazard_fwd_ctrl_fwd_unit.sv
// Per-operand forwarding select: EX/MEM producer beats MEM/WB producer, $0 never forwards.
// Purely combinational, no backpressure.
module hazard_fwd_ctrl_fwd_unit #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_rw,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_rw,
  output logic [1:0]        sel
);
  import hazard_fwd_ctrl_pkg::*;

  logic ex_hit;
  logic mem_hit;

  assign ex_hit  = (src != '0) && ex_rw  && (ex_rd  == src);
  assign mem_hit = (src != '0) && mem_rw && (mem_rd == src);

  always_comb begin
    sel = FWD_RF;
    if (ex_hit) begin
      sel = FWD_EXMEM;
    end else if (mem_hit) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Load-use stall, branch flush and memory freeze control plus registered EX forwarding selects.
// Enables are combinational in the current cycle; selects appear one cycle after ID; mem_wait freezes all state.
module hazard_fwd_ctrl #(
  parameter int REG_AW = hazard_fwd_ctrl_pkg::REG_AW,
  parameter int CNT_W  = hazard_fwd_ctrl_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  hazard_fwd_ctrl_if.slave bus
);
  import hazard_fwd_ctrl_pkg::*;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              rw;
    logic              load;
  } ex_shadow_t;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              rw;
  } mem_shadow_t;

  state_t      state_q, state_d;
  ex_shadow_t  ex_q;
  mem_shadow_t mem_q;
  fwd_sel_t    sel_a, sel_b;
  fwd_sel_t    fwd_a_q, fwd_b_q;
  logic [CNT_W-1:0] cnt_q;

  logic hazard;
  logic take_stall;
  logic advance;
  logic bubble;
  logic cnt_inc;
  logic pc_write, ifid_write, ifid_flush, idex_bubble;

  assign hazard = bus.id_valid && ex_q.load && ex_q.rw && (ex_q.rd != '0) &&
                  ((ex_q.rd == bus.id_rs) || (ex_q.rd == bus.id_rt));

  assign take_stall = hazard && !bus.mem_wait && !bus.flush;

  hazard_fwd_ctrl_fwd_unit #(.REG_AW(REG_AW)) u_fwd_a (
    .src    (bus.id_rs),
    .ex_rd  (ex_q.rd),
    .ex_rw  (ex_q.rw),
    .mem_rd (mem_q.rd),
    .mem_rw (mem_q.rw),
    .sel    (sel_a)
  );

  hazard_fwd_ctrl_fwd_unit #(.REG_AW(REG_AW)) u_fwd_b (
    .src    (bus.id_rt),
    .ex_rd  (ex_q.rd),
    .ex_rw  (ex_q.rw),
    .mem_rd (mem_q.rd),
    .mem_rw (mem_q.rw),
    .sel    (sel_b)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    state_d = bus.mem_wait ? ST_FREEZE : (take_stall ? ST_STALL : ST_RUN);
      ST_STALL:  state_d = bus.mem_wait ? ST_FREEZE : ST_RUN;
      ST_FREEZE: state_d = bus.mem_wait ? ST_FREEZE : (take_stall ? ST_STALL : ST_RUN);
      default:   state_d = ST_RUN;
    endcase
  end

  // Per-cycle priority: reset > mem_wait > flush > load-use > normal.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    advance     = 1'b1;
    bubble      = !bus.id_valid;
    cnt_inc     = 1'b0;
    if (reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      advance     = 1'b0;
    end else if (bus.mem_wait) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      advance     = 1'b0;
      cnt_inc     = 1'b1;
    end else if (bus.flush) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      bubble      = 1'b1;
    end else if (take_stall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      bubble      = 1'b1;
      cnt_inc     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      ex_q    <= '0;
      mem_q   <= '0;
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (advance) begin
        mem_q.rd <= ex_q.rd;
        mem_q.rw <= ex_q.rw;
        if (bubble) begin
          ex_q    <= '0;
          fwd_a_q <= FWD_RF;
          fwd_b_q <= FWD_RF;
        end else begin
          ex_q.rd   <= bus.id_rd;
          ex_q.rw   <= bus.id_reg_write;
          ex_q.load <= bus.id_mem_read;
          fwd_a_q   <= sel_a;
          fwd_b_q   <= sel_b;
        end
      end
      if (cnt_inc && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.fwd_a_sel   = fwd_a_q;
  assign bus.fwd_b_sel   = fwd_b_q;
  assign bus.pc_write    = pc_write;
  assign bus.ifid_write  = ifid_write;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_bubble = idex_bubble;
  assign bus.stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed pipeline sequences for hazard_fwd_ctrl; expected outputs are queued per cycle
// and checked by an independent monitor on the falling edge.
module tb_hazard_fwd_ctrl;
  import hazard_fwd_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  hazard_fwd_ctrl_if #(.REG_AW(5), .CNT_W(16)) bus ();

  hazard_fwd_ctrl #(.REG_AW(5), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       rw;
    logic       ld;
  } instr_t;

  typedef struct {
    logic [3:0]  mask;
    logic [3:0]  ctrl;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [15:0] cnt;
    int          cyc;
  } exp_t;

  // mask bits
  localparam logic [3:0] M_CTL = 4'b0001, M_FA = 4'b0010, M_FB = 4'b0100, M_CNT = 4'b1000;
  localparam logic [3:0] M_ALL = 4'b1111;
  // {pc_write, ifid_write, ifid_flush, idex_bubble}
  localparam logic [3:0] C_RUN = 4'b1100, C_STALL = 4'b0001, C_FRZ = 4'b0000;
  localparam logic [3:0] C_FL  = 4'b1111, C_RST   = 4'b0011;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  function automatic instr_t nop();
    instr_t r;
    r = '0;
    return r;
  endfunction

  function automatic instr_t alu(input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
    instr_t r;
    r.v = 1'b1; r.rs = s; r.rt = t; r.rd = d; r.rw = 1'b1; r.ld = 1'b0;
    return r;
  endfunction

  function automatic instr_t lw(input logic [4:0] d, input logic [4:0] base);
    instr_t r;
    r.v = 1'b1; r.rs = base; r.rt = d; r.rd = d; r.rw = 1'b1; r.ld = 1'b1;
    return r;
  endfunction

  task automatic tick(input logic rst, input instr_t i, input logic fl, input logic mw,
                      input logic [3:0] m, input logic [3:0] c,
                      input logic [1:0] fa, input logic [1:0] fb, input logic [15:0] cnt);
    exp_t e;
    @(posedge clk);
    #1;
    reset            = rst;
    bus.id_valid     = i.v;
    bus.id_rs        = i.rs;
    bus.id_rt        = i.rt;
    bus.id_rd        = i.rd;
    bus.id_reg_write = i.rw;
    bus.id_mem_read  = i.ld;
    bus.flush        = fl;
    bus.mem_wait     = mw;
    cyc++;
    e.mask = m; e.ctrl = c; e.fa = fa; e.fb = fb; e.cnt = cnt; e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic cmp(input string name, input int c, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h", name, c, act, req);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (e.mask[0]) cmp("ctrl", e.cyc,
            16'({bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.idex_bubble}), 16'(e.ctrl));
        if (e.mask[1]) cmp("fwd_a_sel", e.cyc, 16'(bus.fwd_a_sel), 16'(e.fa));
        if (e.mask[2]) cmp("fwd_b_sel", e.cyc, 16'(bus.fwd_b_sel), 16'(e.fb));
        if (e.mask[3]) cmp("stall_count", e.cyc, bus.stall_count, e.cnt);
      end
    end
  end

  initial begin
    bus.id_valid = 1'b0; bus.id_rs = '0; bus.id_rt = '0; bus.id_rd = '0;
    bus.id_reg_write = 1'b0; bus.id_mem_read = 1'b0; bus.flush = 1'b0; bus.mem_wait = 1'b0;

    // reset held two cycles, then release
    tick(1, nop(),          0, 0, M_ALL,                C_RST,   2'b00, 2'b00, 16'd0);
    tick(1, nop(),          0, 0, M_ALL,                C_RST,   2'b00, 2'b00, 16'd0);
    tick(0, nop(),          0, 0, M_CTL | M_CNT,        C_RUN,   2'b00, 2'b00, 16'd0);
    // add $3 ; sub $4,$3,$5 -> EX/MEM forward on A
    tick(0, alu(3, 1, 2),   0, 0, M_CTL,                C_RUN,   2'b00, 2'b00, 16'd0);
    tick(0, alu(4, 3, 5),   0, 0, M_CTL | M_FA | M_FB,  C_RUN,   2'b00, 2'b00, 16'd0);
    tick(0, nop(),          0, 0, M_ALL,                C_RUN,   2'b01, 2'b00, 16'd0);
    // add $8 ; gap ; or $9,$8,$8 -> MEM/WB forward on both
    tick(0, alu(8, 1, 2),   0, 0, M_CTL,                C_RUN,   2'b00, 2'b00, 16'd0);
    tick(0, nop(),          0, 0, M_CTL,                C_RUN,   2'b00, 2'b00, 16'd0);
    tick(0, alu(9, 8, 8),   0, 0, M_CTL | M_FA | M_FB,  C_RUN,   2'b00, 2'b00, 16'd0);
    tick(0, nop(),          0, 0, M_ALL,                C_RUN,   2'b10, 2'b10, 16'd0);
    // lw $2 ; add $6,$2,$2 -> one stall, then MEM/WB forward
    tick(0, lw(2, 1),       0, 0, M_CTL,                C_RUN,   2'b00, 2'b00, 16'd0);
    tick(0, alu(6, 2, 2),   0, 0, M_CTL | M_CNT,        C_STALL, 2'b00, 2'b00, 16'd0);
    tick(0, alu(6, 2, 2),   0, 0, M_CTL | M_CNT,        C_RUN,   2'b00, 2'b00, 16'd1);
    tick(0, nop(),          0, 0, M_ALL,                C_RUN,   2'b10, 2'b10, 16'd1);
    // $7 in both shadows -> EX/MEM wins; write to $0 never forwards
    tick(0, alu(7, 1, 1),   0, 0, M_CTL,                C_RUN,   2'b00, 2'b00, 16'd1);
    tick(0, alu(7, 1, 1),   0, 0, M_CTL,                C_RUN,   2'b00, 2'b00, 16'd1);
    tick(0, alu(10, 7, 0),  0, 0, M_CTL,                C_RUN,   2'b00, 2'b00, 16'd1);
    tick(0, alu(0, 1, 1),   0, 0, M_ALL,                C_RUN,   2'b01, 2'b00, 16'd1);
    tick(0, alu(12, 0, 0),  0, 0, M_CTL,                C_RUN,   2'b00, 2'b00, 16'd1);
    tick(0, nop(),          0, 0, M_ALL,                C_RUN,   2'b00, 2'b00, 16'd1);
    // lw $5,($12) ; sub $13,$5,$1 with mem_wait for 3 cycles on the hazard
    tick(0, lw(5, 12),      0, 0, M_CTL,                C_RUN,   2'b00, 2'b00, 16'd1);
    tick(0, alu(13, 5, 1),  0, 1, M_ALL,                C_FRZ,   2'b10, 2'b00, 16'd1);
    tick(0, alu(13, 5, 1),  0, 1, M_ALL,                C_FRZ,   2'b10, 2'b00, 16'd2);
    tick(0, alu(13, 5, 1),  0, 1, M_ALL,                C_FRZ,   2'b10, 2'b00, 16'd3);
    tick(0, alu(13, 5, 1),  0, 0, M_ALL,                C_STALL, 2'b10, 2'b00, 16'd4);
    tick(0, alu(13, 5, 1),  0, 0, M_CTL | M_CNT,        C_RUN,   2'b00, 2'b00, 16'd5);
    tick(0, nop(),          0, 0, M_ALL,                C_RUN,   2'b10, 2'b00, 16'd5);
    // flush coincident with load-use: no stall, EX shadow cleared
    tick(0, lw(14, 1),      0, 0, M_CTL,                C_RUN,   2'b00, 2'b00, 16'd5);
    tick(0, alu(15, 14, 14), 1, 0, M_CTL | M_CNT,       C_FL,    2'b00, 2'b00, 16'd5);
    tick(0, alu(16, 14, 1), 0, 0, M_CTL | M_CNT,        C_RUN,   2'b00, 2'b00, 16'd5);
    tick(0, nop(),          0, 0, M_ALL,                C_RUN,   2'b10, 2'b00, 16'd5);
    // reset outranks mem_wait and clears the counter
    tick(1, nop(),          0, 1, M_CTL | M_CNT,        C_RST,   2'b00, 2'b00, 16'd5);
    tick(1, nop(),          0, 0, M_ALL,                C_RST,   2'b00, 2'b00, 16'd0);

    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (exp_q.size() != 0) @(negedge clk);
    end
    #1;
    cmp("drain", cyc, 16'(exp_q.size()), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
